// File: rtl/systolic_feeder.sv
// systolic_feeder: drains LANES show-ahead FIFOs in lockstep and skews lane i by i
// cycles so each popped vector enters the systolic array as a diagonal wavefront.
module systolic_feeder #(
   parameter int WIDTH = 16,
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   enb,
   input  logic                   start,
   input  logic                   flush,
   input  logic [CNT_W-1:0]       tile_len,
   input  logic [LANES-1:0]       fifo_empty,
   input  logic [LANES*WIDTH-1:0] fifo_data,
   output logic [LANES-1:0]       fifo_r_en,
   output logic [LANES*WIDTH-1:0] to_systolic_array,
   output logic [LANES-1:0]       valid_out,
   output logic                   stall,
   output logic                   busy,
   output logic                   done
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
   state_t state;
   logic [CNT_W-1:0] remaining, drain_cnt;
   logic pop, shift;

   assign pop = state == FEED && enb && !(|fifo_empty) && !flush;
   // IDLE and DONE keep shifting so residual data always leaves the skew lines
   assign shift = enb || state == IDLE || state == DONE;
   assign fifo_r_en = {LANES{pop}};
   assign stall = state == FEED && enb && |fifo_empty;
   assign busy = state != IDLE;
   assign done = state == DONE;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         remaining <= '0;
         drain_cnt <= '0;
      end else if (flush) begin
         state <= IDLE;
         remaining <= '0;
         drain_cnt <= '0;
      end else
         case (state)
            IDLE:
               if (enb && start && tile_len != '0) begin
                  state <= FEED;
                  remaining <= tile_len;
               end
            FEED:
               if (pop) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_W'(1)) state <= LANES > 1 ? DRAIN : DONE;
               end
            DRAIN:
               if (enb) begin
                  if (drain_cnt == CNT_W'(LANES - 2)) begin
                     state <= DONE;
                     drain_cnt <= '0;
                  end else
                     drain_cnt <= drain_cnt + 1'b1;
               end
            default: state <= IDLE;
         endcase

   // Each lane carries {valid, data}; an empty slot is all zeros, so invalid data reads 0
   genvar i;
   for (i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH:0] d [0:i];
      logic [WIDTH:0] head;
      assign head = pop ? {1'b1, fifo_data[i*WIDTH +: WIDTH]} : '0;
      always_ff @(posedge clk or negedge rstn)
         if (!rstn)
            for (int k = 0; k <= i; k++) d[k] <= '0;
         else if (flush)
            for (int k = 0; k <= i; k++) d[k] <= '0;
         else if (shift) begin
            d[0] <= head;
            for (int k = 1; k <= i; k++) d[k] <= d[k-1];
         end
      assign to_systolic_array[i*WIDTH +: WIDTH] = d[i][WIDTH-1:0];
      assign valid_out[i] = d[i][WIDTH];
   end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Multi-lane, skewing successor to the single-lane FIFO consumer. It drains `LANES` show-ahead sync FIFOs in lockstep, one vector per pop, and staggers lane `i` by `i` cycles so the vector enters the systolic array as a diagonal wavefront. It counts a programmed tile length and then flushes the skew pipeline. It raises `done` in the cycle the last element leaves the last lane. It sits between the per-row/column input FIFOs and the systolic array edge.

## Interface
- `WIDTH`, 16, bits per lane element
- `LANES`, 4, number of lanes (rows/columns fed), >= 1
- `CNT_W`, 16, width of tile length counter

- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `enb`  in  1  advance enable; 0 freezes all state, counters, pipeline and outputs
- `start`  in  1  begin a tile; sampled only in IDLE
- `flush`  in  1  synchronous abort; clears pipeline, returns to IDLE, no `done`
- `tile_len`  in  CNT_W  vectors per tile; latched on accepted `start`
- `fifo_empty`  in  LANES  per-lane FIFO empty
- `fifo_data`  in  LANES*WIDTH  per-lane show-ahead head word, lane i at [i*WIDTH +: WIDTH]; valid while its empty is 0
- `fifo_r_en`  out  LANES  per-lane pop, all bits identical
- `to_systolic_array`  out  LANES*WIDTH  skewed lane outputs, registered
- `valid_out`  out  LANES  per-lane element valid
- `stall`  out  1  FEED, enb=1, and any lane empty
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at tile completion

## Operation
- Reset (async, rstn=0): state IDLE; all outputs, counters and pipeline regs 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 and `tile_len`!=0 -> FEED; remaining <= tile_len.
  - `start` with `tile_len`=0 is ignored.
- FEED:
  - pop = enb & ~|fifo_empty.
  - On pop: all `fifo_r_en`=1 (combinational). Stage 0 captures every lane's head with valid=1. remaining decrements.
  - On enb=1 with no pop: stage 0 takes a zero bubble with valid=0. The pipeline still advances, so skew alignment is kept.
  - A pop with remaining==1 -> DRAIN if LANES>1, else DONE.
- DRAIN:
  - Lasts LANES-1 enabled cycles, counted by a drain counter.
  - Stage 0 takes zeros with valid=0.
  - After the last drain cycle -> DONE.
- DONE: `done`=1 for one cycle -> IDLE. Pipeline advances with zero inserts.
- IDLE/DONE pipeline: shifts in zeros every cycle regardless of enb, so residual data leaves.
- Skew: lane i output = stage-0 value delayed i further registers. Lane 0 is the stage-0 register itself.
- An invalid slot always drives data 0 (never stale data).
- `fifo_r_en` is never asserted outside FEED, or when any lane is empty, or when enb=0.
- `flush`:
  - Has priority over everything except reset.
  - Next edge: state IDLE, pipeline and `valid_out` cleared, counters 0, `done` not pulsed.
  - `fifo_r_en` is 0 in the flush cycle.
- `start`/`tile_len` while busy: ignored.
- Reset mid-tile: immediate return to reset values. FIFO contents are not the feeder's concern.

## Timing
- Pop sampled at edge E: lane i shows that element in cycle E+1+i (lane 0 latency 1, matching the previous consumer).
- Final pop in cycle c: DRAIN covers c+1..c+LANES-1. DONE and `done`=1 in cycle c+LANES, coincident with last lane's `valid_out`=1.
- enb=0 cycles stretch all of the above one-for-one; outputs hold.
- `stall` is combinational from `fifo_empty`; `busy` and `done` are registered-state decodes.
- Throughput: one vector per cycle when all FIFOs are non-empty and enb=1.

## Test plan
- LANES=4, tile_len=3, all FIFOs preloaded with lane-coded values (lane i word k = 16*i+k), enb=1. Expected response:
  - `fifo_r_en`=4'hF for 3 cycles.
  - Lane i shows i*16+0..2 in cycles 1+i..3+i after the first pop.
  - `done` in cycle 4 after the final pop, `busy` low next cycle.
- Same tile, but lane 2 empty for 2 cycles mid-tile. Expected response:
  - `stall`=1 and `fifo_r_en`=0 for those 2 cycles.
  - A 2-slot zero bubble with `valid_out`=0 appears on every lane, each offset by its skew.
  - Diagonal order is preserved and `done` is delayed by 2.
- enb held low 3 cycles during DRAIN -> outputs, counters and state frozen; `done` slips exactly 3 cycles.
- `flush` asserted in the second FEED cycle of tile_len=8 -> IDLE next edge, all `valid_out`=0, no `done`. A following `start` with tile_len=2 completes normally.
- `start` with tile_len=0 -> stays IDLE, no `fifo_r_en`, no `done`. Also: rstn pulsed low mid-FEED asynchronously (between edges) -> outputs 0 immediately.
- LANES=1, tile_len=1 -> single pop, lane 0 valid next cycle with `done`=1 in that same cycle (no DRAIN cycles).
